fabric_extmem_req_arbiter: RTL and testbench
============================================

// Module: fabric_extmem_req_arbiter
// PURPOSE
//  Shares one tagged external-memory load port among NUM_REQ untagged requesters.
//  Round-robin grants requests onto a single registered request stream, stamping the requester index as tag.
//  Routes tagged responses back to the owning requester and strips the tag.
//  Sits between PE-side load ports and a fabric_extmemory load port; enforces per-requester outstanding credit.
// PARAMETERS
//  DATA_WIDTH      32  address/data payload width (>=1)
//  NUM_REQ         4   requester count (>=2)
//  MAX_OUTSTANDING 4   per-requester in-flight limit (>=1)
//  TAG_WIDTH       localparam = $clog2(NUM_REQ); PW = DATA_WIDTH+TAG_WIDTH
// PORTS
//  clk            in   1                   clock
//  rst_n          in   1                   async active-low reset
//  req_valid      in   NUM_REQ             requester address valid
//  req_ready      out  NUM_REQ             requester address accepted
//  req_data       in   NUM_REQ x DATA_WIDTH  requester address
//  mem_req_valid  out  1                   tagged request to memory
//  mem_req_ready  in   1                   memory accepts request
//  mem_req_data   out  PW                  {tag, addr}
//  mem_rsp_valid  in   1                   tagged load data from memory
//  mem_rsp_ready  out  1                   response consumed
//  mem_rsp_data   in   PW                  {tag, data}
//  rsp_valid      out  NUM_REQ             per-requester load data valid
//  rsp_ready      in   NUM_REQ             per-requester load data ready
//  rsp_data       out  NUM_REQ x DATA_WIDTH  untagged load data
//  error_valid    out  1                   sticky error flag
//  error_code     out  16                  first error code
// BEHAVIOUR
//  Reset: mem_req_valid=0, mem_req_data=0, rr_ptr=0, all credit counters=0, error_valid=0, error_code=0.
//  Eligible(i) = req_valid[i] && credit[i] < MAX_OUTSTANDING.
//  Slot free = !mem_req_valid || mem_req_ready.
//  When slot free and any eligible: grant first eligible at or after rr_ptr (wrapping NUM_REQ-1 -> 0).
//  req_ready[g]=1 for granted g only; all other req_ready=0; no grant when slot not free.
//  Request latency 1 cycle: granted {g, addr} registered into mem_req_*, held stable until mem_req_ready.
//  On grant: rr_ptr <= g+1 (wrapping); credit[g]++. No grant: rr_ptr unchanged.
//  Response path combinational: t = tag field.
//    t < NUM_REQ: rsp_valid[t] = mem_rsp_valid; rsp_data[t] = data field; mem_rsp_ready = rsp_ready[t].
//    Handshake on tag t decrements credit[t].
//  Same-cycle grant and response on one requester: credit unchanged.
//  Credit saturates: eligibility blocks further grants at MAX_OUTSTANDING; never wraps.
//  Errors: t >= NUM_REQ -> RT_MEMORY_TAG_OOB, response dropped (mem_rsp_ready=1).
//    Valid response to requester with credit==0 -> RT_ARB_RSP_UNEXPECTED; response still delivered; credit stays 0.
//  Error latch: first error captured; later errors ignored until reset (OOB wins when simultaneous).
//  Async reset mid-transfer: pending request and all credits discarded immediately.
// CONFIGURATION
//  FABRIC_EXTMEM_ARB_STALL_CNT_EN defined:
//    Adds output stall_cnt[31:0] (reset 0).
//    Increments each cycle with mem_req_valid && !mem_req_ready; saturates at 32'hFFFF_FFFF.
//  Undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Shared fabric_common.svh: RT_MEMORY_TAG_OOB (existing); new RT_ARB_RSP_UNEXPECTED code.
//  Sub-module fabric_rr_arbiter #(N):
//    inputs: eligible vector, rr_ptr
//    outputs: one-hot grant, grant index, any_grant
//    purely combinational
//  Pointer, credit counters, output register and error latch live in the top module.
// TESTING
//  1. All 4 req_valid held, mem_req_ready=1 -> tags 0,1,2,3,0 on consecutive cycles.
//  2. mem_req_ready=0 for 3 cycles -> mem_req_data stable; req_ready all 0; single grant issued after release.
//  3. Requester 1 issues 4 with no responses (MAX=4) -> 5th blocked; one tag-1 response -> next req 1 granted.
//  4. Response tag=2 data=0xDEAD with rsp_ready[2]=0 -> mem_rsp_ready=0; raise rsp_ready[2] -> rsp_data[2]=0xDEAD, credit[2]--.
//  5. Response tag=1 with credit[1]=0 -> error_code=RT_ARB_RSP_UNEXPECTED; later OOB tag does not overwrite.
//  6. NUM_REQ=3, response tag=3 -> error_code=RT_MEMORY_TAG_OOB; response dropped; rst_n pulse clears all state.

Source files
------------

// File: rtl/fabric_extmem_req_arbiter_pkg.sv
// Shared definitions for the external-memory request arbiter: error codes and sizing helpers.
package fabric_extmem_req_arbiter_pkg;

    localparam logic [15:0] RT_MEMORY_TAG_OOB     = 16'h0011;
    localparam logic [15:0] RT_ARB_RSP_UNEXPECTED = 16'h0012;

    function automatic int credit_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/fabric_extmem_req_arbiter_if.sv
// Handshake bundle between NUM_REQ untagged requesters, the arbiter and one tagged memory port.
interface fabric_extmem_req_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    localparam int TAG_WIDTH = $clog2(NUM_REQ);
    localparam int PW        = DATA_WIDTH + TAG_WIDTH;

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic                               mem_req_valid;
    logic                               mem_req_ready;
    logic [PW-1:0]                      mem_req_data;
    logic                               mem_rsp_valid;
    logic                               mem_rsp_ready;
    logic [PW-1:0]                      mem_rsp_data;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [NUM_REQ-1:0]                 rsp_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_data;

    modport slave (
        input  req_valid, req_data, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
        output req_ready, mem_req_valid, mem_req_data, mem_rsp_ready, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_data, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
        input  req_ready, mem_req_valid, mem_req_data, mem_rsp_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/fabric_extmem_req_arbiter_rr.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, wrapping at N-1.
module fabric_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);
    localparam logic [IW:0] N_V = (IW+1)'(N);

    logic [IW:0] sum;

    // Scan from the farthest offset down so the nearest eligible index is written last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= N_V) begin
                sum = sum - N_V;
            end
            if (eligible[sum[IW-1:0]]) begin
                grant                 = '0;
                grant[sum[IW-1:0]]    = 1'b1;
                grant_idx             = sum[IW-1:0];
                any_grant             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fabric_extmem_req_arbiter.sv
// Round-robin arbiter sharing one tagged memory load port with per-requester credits.
// Optional FABRIC_EXTMEM_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module fabric_extmem_req_arbiter
    import fabric_extmem_req_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fabric_extmem_req_arbiter_if.slave    bus,
    output logic                          error_valid,
    output logic [15:0]                   error_code
`ifdef FABRIC_EXTMEM_ARB_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt
`endif
);
    localparam int TAG_WIDTH = $clog2(NUM_REQ);
    localparam int PW        = DATA_WIDTH + TAG_WIDTH;
    localparam int CW        = credit_width(MAX_OUTSTANDING);

    localparam logic [CW-1:0]        CREDIT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [TAG_WIDTH-1:0] LAST_IDX   = TAG_WIDTH'(NUM_REQ - 1);
    localparam logic [TAG_WIDTH:0]   NUM_REQ_V  = (TAG_WIDTH+1)'(NUM_REQ);

    logic                 mem_req_valid_reg;
    logic [PW-1:0]        mem_req_data_reg;
    logic [TAG_WIDTH-1:0] rr_ptr_reg;
    logic [TAG_WIDTH-1:0] rr_ptr_next;
    logic [CW-1:0]        credit_reg [NUM_REQ];
    logic                 error_valid_reg;
    logic [15:0]          error_code_reg;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [TAG_WIDTH-1:0] grant_idx;
    logic                 any_grant;
    logic                 slot_free;
    logic                 grant_en;
    logic [NUM_REQ-1:0]   grant_vec;

    logic [TAG_WIDTH-1:0]  rsp_tag;
    logic [DATA_WIDTH-1:0] rsp_payload;
    logic                  tag_ok;
    logic [NUM_REQ-1:0]    rsp_sel;
    logic [NUM_REQ-1:0]    rsp_hs;
    logic [NUM_REQ-1:0]    rsp_unexp;
    logic                  oob_evt;
    logic                  unexp_evt;

    assign slot_free = !mem_req_valid_reg || bus.mem_req_ready;
    assign grant_en  = slot_free && any_grant;
    assign grant_vec = grant_en ? grant_oh : '0;

    assign rsp_tag     = bus.mem_rsp_data[PW-1:DATA_WIDTH];
    assign rsp_payload = bus.mem_rsp_data[DATA_WIDTH-1:0];
    assign tag_ok      = {1'b0, rsp_tag} < NUM_REQ_V;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign eligible[gi]      = bus.req_valid[gi] && (credit_reg[gi] < CREDIT_MAX);
            assign rsp_sel[gi]       = tag_ok && (rsp_tag == TAG_WIDTH'(gi));
            assign bus.rsp_valid[gi] = bus.mem_rsp_valid && rsp_sel[gi];
            assign bus.rsp_data[gi]  = rsp_payload;
            assign rsp_hs[gi]        = bus.rsp_valid[gi] && bus.rsp_ready[gi];
            assign rsp_unexp[gi]     = bus.rsp_valid[gi] && (credit_reg[gi] == '0);
        end
    endgenerate

    fabric_rr_arbiter #(.N(NUM_REQ), .IW(TAG_WIDTH)) u_rr (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Out-of-range tags have no consumer, so they are always swallowed.
    assign bus.mem_rsp_ready = tag_ok ? |(rsp_sel & bus.rsp_ready) : 1'b1;
    assign bus.req_ready     = grant_vec;
    assign bus.mem_req_valid = mem_req_valid_reg;
    assign bus.mem_req_data  = mem_req_data_reg;
    assign oob_evt           = bus.mem_rsp_valid && !tag_ok;
    assign unexp_evt         = |rsp_unexp;
    assign rr_ptr_next       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    assign error_valid       = error_valid_reg;
    assign error_code        = error_code_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_valid_reg <= 1'b0;
            mem_req_data_reg  <= '0;
            rr_ptr_reg        <= '0;
        end else if (grant_en) begin
            mem_req_valid_reg <= 1'b1;
            mem_req_data_reg  <= {grant_idx, bus.req_data[grant_idx]};
            rr_ptr_reg        <= rr_ptr_next;
        end else if (bus.mem_req_ready) begin
            mem_req_valid_reg <= 1'b0;
        end
    end

    // A grant and a response handshake on the same requester cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) credit_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_vec[i] && !rsp_hs[i]) begin
                    credit_reg[i] <= credit_reg[i] + 1'b1;
                end else if (rsp_hs[i] && !grant_vec[i] && credit_reg[i] != '0) begin
                    credit_reg[i] <= credit_reg[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_valid_reg <= 1'b0;
            error_code_reg  <= '0;
        end else if (!error_valid_reg) begin
            if (oob_evt) begin
                error_valid_reg <= 1'b1;
                error_code_reg  <= RT_MEMORY_TAG_OOB;
            end else if (unexp_evt) begin
                error_valid_reg <= 1'b1;
                error_code_reg  <= RT_ARB_RSP_UNEXPECTED;
            end
        end
    end

`ifdef FABRIC_EXTMEM_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (mem_req_valid_reg && !bus.mem_req_ready && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fabric_extmem_req_arbiter.sv
// Directed and randomized bench for fabric_extmem_req_arbiter against a transaction-level model.
module tb_fabric_extmem_req_arbiter;
    import fabric_extmem_req_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fabric_extmem_req_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus4();
    fabric_extmem_req_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(3)) bus3();

    logic        ev4, ev3;
    logic [15:0] ec4, ec3;
`ifdef FABRIC_EXTMEM_ARB_STALL_CNT_EN
    logic [31:0] sc4, sc3;
`endif

    fabric_extmem_req_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_OUTSTANDING(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .error_valid(ev4), .error_code(ec4)
`ifdef FABRIC_EXTMEM_ARB_STALL_CNT_EN
        , .stall_cnt(sc4)
`endif
    );

    fabric_extmem_req_arbiter #(.DATA_WIDTH(32), .NUM_REQ(3), .MAX_OUTSTANDING(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .error_valid(ev3), .error_code(ec3)
`ifdef FABRIC_EXTMEM_ARB_STALL_CNT_EN
        , .stall_cnt(sc3)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Transaction-level model of the 4-requester instance.
    int          m_credit [4];
    int          m_ptr;
    bit          m_pv;
    logic [33:0] m_pd;
    bit          m_ev;
    logic [15:0] m_ec;
    longint      m_stall;
    bit          log_en = 1'b0;
    int          tag_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus4.req_valid = '0; bus4.mem_req_ready = 1'b0; bus4.mem_rsp_valid = 1'b0;
        bus4.mem_rsp_data = '0; bus4.rsp_ready = '0;
        bus3.req_valid = '0; bus3.mem_req_ready = 1'b0; bus3.mem_rsp_valid = 1'b0;
        bus3.mem_rsp_data = '0; bus3.rsp_ready = '0;
        for (int i = 0; i < 4; i++) bus4.req_data[i] = $urandom;
        for (int i = 0; i < 3; i++) bus3.req_data[i] = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_mem_req_valid", bus4.mem_req_valid, 0);
        chk("rst_mem_req_data", bus4.mem_req_data, 0);
        chk("rst_error_valid", ev4, 0);
        chk("rst_error_code", ec4, 0);
        chk("rst3_mem_req_valid", bus3.mem_req_valid, 0);
        chk("rst3_error", {ev3, ec3}, 0);
        for (int i = 0; i < 4; i++) m_credit[i] = 0;
        m_ptr = 0; m_pv = 1'b0; m_pd = '0; m_ev = 1'b0; m_ec = '0; m_stall = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drive4(input logic [3:0] rv, input logic mrr, input logic mv,
                          input int tag, input logic [31:0] d, input logic [3:0] rr);
        bus4.req_valid = rv; bus4.mem_req_ready = mrr; bus4.mem_rsp_valid = mv;
        bus4.mem_rsp_data = {2'(tag), d}; bus4.rsp_ready = rr;
        for (int i = 0; i < 4; i++) bus4.req_data[i] = $urandom;
    endtask

    // Compare the 4-requester DUT with the model, then advance the model by one clock.
    task automatic check_update4();
        int g, t, idx;
        bit hs, unexp;
        g = -1;
        if (!m_pv || bus4.mem_req_ready) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (g < 0 && bus4.req_valid[idx] && m_credit[idx] < 4) g = idx;
            end
        end
        chk("req_ready", bus4.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("mem_req_valid", bus4.mem_req_valid, m_pv);
        if (m_pv) chk("mem_req_data", bus4.mem_req_data, m_pd);
        if (log_en && bus4.mem_req_valid) tag_log.push_back(int'(bus4.mem_req_data[33:32]));
        t = int'(bus4.mem_rsp_data[33:32]);
        chk("rsp_valid", bus4.rsp_valid, bus4.mem_rsp_valid ? (64'd1 << t) : 64'd0);
        if (bus4.mem_rsp_valid) begin
            chk("rsp_data", bus4.rsp_data[t], bus4.mem_rsp_data[31:0]);
            chk("mem_rsp_ready", bus4.mem_rsp_ready, bus4.rsp_ready[t]);
        end
        chk("error_valid", ev4, m_ev);
        chk("error_code", ec4, m_ec);
`ifdef FABRIC_EXTMEM_ARB_STALL_CNT_EN
        chk("stall_cnt", sc4, m_stall);
`endif
        hs    = bus4.mem_rsp_valid && bus4.rsp_ready[t];
        unexp = bus4.mem_rsp_valid && m_credit[t] == 0;
        if (!m_ev && unexp) begin m_ev = 1'b1; m_ec = RT_ARB_RSP_UNEXPECTED; end
        if (!(g >= 0 && hs && g == t)) begin
            if (g >= 0) m_credit[g]++;
            if (hs && m_credit[t] > 0) m_credit[t]--;
        end
        if (hs) $display("[TB] t=%0t rsp tag=%0d data=%08h", $time, t, bus4.mem_rsp_data[31:0]);
        if (m_pv && !bus4.mem_req_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (g >= 0) begin
            m_pv = 1'b1;
            m_pd = {2'(g), bus4.req_data[g]};
            m_ptr = (g + 1) % 4;
            $display("[TB] t=%0t grant req=%0d addr=%08h", $time, g, bus4.req_data[g]);
        end else if (bus4.mem_req_ready) begin
            m_pv = 1'b0;
        end
    endtask

    task automatic step4();
        @(negedge clk);
        check_update4();
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_tags [5];
        int t;
        logic [33:0] held;
        exp_tags = '{0, 1, 2, 3, 0};

        do_reset();

        // All four requesting with a free memory port: strict rotation.
        log_en = 1'b1;
        for (int c = 0; c < 6; c++) begin drive4(4'hF, 1'b1, 1'b0, 0, 0, 4'h0); step4(); end
        log_en = 1'b0;
        chk("rot_count", tag_log.size(), 5);
        for (int i = 0; i < 5 && i < tag_log.size(); i++) chk($sformatf("rot_tag%0d", i), tag_log[i], exp_tags[i]);

        // Memory backpressure: request held, nobody granted.
        held = bus4.mem_req_data;
        for (int c = 0; c < 3; c++) begin
            drive4(4'hF, 1'b0, 1'b0, 0, 0, 4'h0);
            @(negedge clk);
            chk("stall_hold", bus4.mem_req_data, held);
            chk("stall_rdy", bus4.req_ready, 0);
            check_update4();
            @(posedge clk); #1;
        end
        drive4(4'hF, 1'b1, 1'b0, 0, 0, 4'h0); step4();
        drive4(4'h0, 1'b1, 1'b0, 0, 0, 4'h0); step4();

        // Credit exhaustion on requester 1.
        do_reset();
        for (int c = 0; c < 4; c++) begin drive4(4'b0010, 1'b1, 1'b0, 0, 0, 4'h0); step4(); end
        drive4(4'b0010, 1'b1, 1'b0, 0, 0, 4'h0);
        @(negedge clk); chk("credit_block", bus4.req_ready, 0); check_update4(); @(posedge clk); #1;
        drive4(4'b0010, 1'b1, 1'b1, 1, 32'h1111_0001, 4'b0010); step4();
        drive4(4'b0010, 1'b1, 1'b0, 0, 0, 4'h0);
        @(negedge clk); chk("credit_return", bus4.req_ready, 4'b0010); check_update4(); @(posedge clk); #1;

        // Response to a requester that is not ready yet.
        do_reset();
        drive4(4'b0100, 1'b1, 1'b0, 0, 0, 4'h0); step4();
        drive4(4'b0000, 1'b1, 1'b1, 2, 32'h0000_DEAD, 4'b0000);
        @(negedge clk); chk("rsp_stall", bus4.mem_rsp_ready, 0); check_update4(); @(posedge clk); #1;
        drive4(4'b0000, 1'b1, 1'b1, 2, 32'h0000_DEAD, 4'b0100);
        @(negedge clk);
        chk("rsp_dead", bus4.rsp_data[2], 32'h0000_DEAD);
        chk("rsp_dead_rdy", bus4.mem_rsp_ready, 1);
        check_update4(); @(posedge clk); #1;
        drive4(4'b0000, 1'b1, 1'b0, 0, 0, 4'h0); step4();

        // Unexpected response.
        do_reset();
        drive4(4'b0000, 1'b1, 1'b1, 1, 32'h5555_0000, 4'hF); step4();
        drive4(4'b0000, 1'b1, 1'b0, 0, 0, 4'h0);
        @(negedge clk); chk("unexp_code", ec4, RT_ARB_RSP_UNEXPECTED); check_update4(); @(posedge clk); #1;

        // Randomized traffic with one asynchronous reset while a request is pending.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            t = $urandom_range(0, 3);
            if (m_credit[t] == 0) for (int k = 0; k < 4; k++) if (m_credit[k] > 0) t = k;
            drive4(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   t, $urandom, 4'($urandom | $urandom));
            if (c == 200) begin
                drive4(4'hF, 1'b0, 1'b0, 0, 0, 4'h0); step4();
                chk("pend_before_rst", bus4.mem_req_valid, 1);
                do_reset();
            end else begin
                step4();
            end
        end

        // Three-requester instance: error latch ordering.
        do_reset();
        bus3.mem_rsp_valid = 1'b1; bus3.mem_rsp_data = {2'd1, 32'h1234}; bus3.rsp_ready = 3'b111;
        @(negedge clk); chk("n3_rsp_valid", bus3.rsp_valid, 3'b010);
        @(posedge clk); #1;
        bus3.mem_rsp_data = {2'd3, 32'hBAD0};
        @(negedge clk);
        chk("n3_unexp_code", ec3, RT_ARB_RSP_UNEXPECTED);
        chk("n3_oob_drop", {bus3.mem_rsp_ready, bus3.rsp_valid}, 4'b1000);
        @(posedge clk); #1;
        bus3.mem_rsp_valid = 1'b0;
        @(negedge clk); chk("n3_no_overwrite", ec3, RT_ARB_RSP_UNEXPECTED);
        @(posedge clk); #1;

        // Out-of-range tag first, then reset clears the pending request and credits.
        do_reset();
        bus3.req_valid = 3'b001; bus3.mem_req_ready = 1'b1; bus3.req_data[0] = 32'hA0A0_0000;
        @(posedge clk); #1;
        bus3.req_valid = 3'b000; bus3.mem_req_ready = 1'b0;
        bus3.mem_rsp_valid = 1'b1; bus3.mem_rsp_data = {2'd3, 32'h0BAD}; bus3.rsp_ready = 3'b000;
        @(negedge clk);
        chk("n3_oob_ready", bus3.mem_rsp_ready, 1);
        chk("n3_oob_rspv", bus3.rsp_valid, 0);
        chk("n3_req_data", bus3.mem_req_data, {2'd0, 32'hA0A0_0000});
        @(posedge clk); #1;
        bus3.mem_rsp_data = {2'd1, 32'h0001}; bus3.rsp_ready = 3'b111;
        @(negedge clk);
        chk("n3_oob_code", {ev3, ec3}, {1'b1, RT_MEMORY_TAG_OOB});
        chk("n3_pending", bus3.mem_req_valid, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("n3_oob_kept", ec3, RT_MEMORY_TAG_OOB);
        @(posedge clk); #1;
        do_reset();
        bus3.mem_rsp_valid = 1'b1; bus3.mem_rsp_data = {2'd0, 32'h0002}; bus3.rsp_ready = 3'b111;
        @(posedge clk); #1;
        bus3.mem_rsp_valid = 1'b0;
        @(negedge clk); chk("n3_credit_cleared", ec3, RT_ARB_RSP_UNEXPECTED);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
